// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: default address width,
// register-file forward code, stage indices and per-entry control flags.
package hazard_scoreboard_pkg;

    localparam int REG_AW_DEF = 5;

    // Forward-select code meaning "use the register-file value"
    localparam int FWD_RF = 0;

    // Stage indices of the tracked entries after ID
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // Control flags carried by each in-flight entry
    typedef struct packed {
        logic valid;
        logic wr;    // writes a non-zero destination register
        logic load;
    } sb_flags_t;

    // Entry holds a load whose destination can still be consumed
    function automatic logic is_load_writer(input sb_flags_t f);
        return f.valid & f.wr & f.load;
    endfunction

    // Entry produces a result that can be forwarded
    function automatic logic is_writer(input sb_flags_t f);
        return f.valid & f.wr;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX side-band bundle between the decode stage and the hazard scoreboard.
// master = decode/pipeline control, slave = scoreboard.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int DEPTH   = STG_WB + 1,
    parameter int NUM_SRC = 2
);
    localparam int FWD_W = $clog2(DEPTH);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_we;
    logic                      id_load;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*FWD_W-1:0]  ex_fwd_sel;
    logic                      ex_valid;

    modport master (
        output id_valid, id_src, id_src_used, id_rd, id_we, id_load, flush,
        input  stall, ex_fwd_sel, ex_valid
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_rd, id_we, id_load, flush,
        output stall, ex_fwd_sel, ex_valid
    );

endinterface

// File: rtl/hazard_scoreboard_chk.sv
// Simulation checks for the hazard scoreboard: a forwarded load must already
// have reached the stage that carries its data, and the configuration must
// be legal.
module hazard_scoreboard_chk
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STAGE = 2,
    parameter int FWD_W      = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic [NUM_SRC*FWD_W-1:0] fwd_sel,
    input logic [NUM_SRC-1:0]       fwd_load
);

    logic early_load_s;

    // Flag any source that forwards from a load before its data exists
    always_comb begin
        early_load_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            early_load_s = early_load_s |
                (fwd_load[s] & (int'(fwd_sel[s*FWD_W +: FWD_W]) < LOAD_STAGE));
        end
    end

    fwd_load_ready_a: assert property (@(posedge clk) disable iff (!rst_n) !early_load_s);

    cfg_legal_a: assert property (@(posedge clk) (DEPTH > STG_MEM) && (LOAD_STAGE > STG_EX));

endmodule

// File: rtl/hazard_scoreboard_match.sv
// One source address compared against every tracked entry. Returns whether a
// candidate entry matches, the lowest (youngest) matching stage index and the
// load flag of that entry. Register 0 never matches.
module hazard_scoreboard_match #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FWD_W  = 2
) (
    input  logic [REG_AW-1:0]       addr,
    input  logic                    en,
    input  logic [DEPTH*REG_AW-1:0] rd_vec,
    input  logic [DEPTH-1:0]        cand,
    input  logic [DEPTH-1:0]        load_vec,
    output logic                    hit,
    output logic [FWD_W-1:0]        idx,
    output logic                    load_hit
);

    // Scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        load_hit = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (en && (addr != '0) && cand[k] &&
                (rd_vec[k*REG_AW +: REG_AW] == addr)) begin
                hit      = 1'b1;
                idx      = FWD_W'(k);
                load_hit = load_vec[k];
            end else begin
                hit      = hit;
                idx      = idx;
                load_hit = load_hit;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the in-order pipeline. Tracks the destination of
// DEPTH in-flight instructions (entry 0 = EX ... DEPTH-1 = WB), raises a
// load-use stall for the instruction in ID and drives per-source forward
// selects for the instruction in EX.
// Optional build macro HAZARD_PERF_EN adds stall/forward cycle counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int DEPTH      = STG_WB + 1,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STAGE = STG_WB
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave sb
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_fwd_cnt
`endif
);

    localparam int FWD_W = $clog2(DEPTH);

    // Scoreboard state. Only the EX entry needs its sources: older entries
    // are only ever matched by destination.
    sb_flags_t                     flags_r [DEPTH];
    logic [DEPTH-1:0][REG_AW-1:0]  rd_r;
    logic [NUM_SRC*REG_AW-1:0]     src0_r;
    logic [NUM_SRC-1:0]            used0_r;

    logic [DEPTH-1:0]              stall_cand_s;
    logic [DEPTH-1:0]              fwd_cand_s;
    logic [DEPTH-1:0]              load_vec_s;
    logic [NUM_SRC-1:0]            stall_hit_s;
    logic [NUM_SRC-1:0]            stall_load_s;
    logic [NUM_SRC-1:0][FWD_W-1:0] stall_idx_s;
    logic [NUM_SRC-1:0]            fwd_hit_s;
    logic [NUM_SRC-1:0]            fwd_load_s;
    logic [NUM_SRC-1:0][FWD_W-1:0] fwd_idx_s;
    logic [NUM_SRC*FWD_W-1:0]      ex_fwd_sel_s;
    logic                          stall_s;
    logic                          issue_s;
    logic                          unused_stall_idx_s;

    // Candidate masks: stalls only for loads still too young to forward,
    // forwarding only from stages behind EX
    always_comb begin
        stall_cand_s = '0;
        fwd_cand_s   = '0;
        load_vec_s   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stall_cand_s[k] = is_load_writer(flags_r[k]) & ((k + 1) < LOAD_STAGE);
            fwd_cand_s[k]   = is_writer(flags_r[k]) & (k != STG_EX);
            load_vec_s[k]   = flags_r[k].load;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_scoreboard_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .FWD_W  (FWD_W)
        ) u_stall_match (
            .addr     (sb.id_src[s*REG_AW +: REG_AW]),
            .en       (sb.id_src_used[s]),
            .rd_vec   (rd_r),
            .cand     (stall_cand_s),
            .load_vec (load_vec_s),
            .hit      (stall_hit_s[s]),
            .idx      (stall_idx_s[s]),
            .load_hit (stall_load_s[s])
        );

        hazard_scoreboard_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .FWD_W  (FWD_W)
        ) u_fwd_match (
            .addr     (src0_r[s*REG_AW +: REG_AW]),
            .en       (flags_r[STG_EX].valid & used0_r[s]),
            .rd_vec   (rd_r),
            .cand     (fwd_cand_s),
            .load_vec (load_vec_s),
            .hit      (fwd_hit_s[s]),
            .idx      (fwd_idx_s[s]),
            .load_hit (fwd_load_s[s])
        );
    end

    // The stall only needs to know that a hazard exists, not where
    assign unused_stall_idx_s = ^stall_idx_s;

    // Load-use stall for the ID instruction; a flush kills it instead
    always_comb begin
        if (sb.id_valid && !sb.flush) begin
            stall_s = |(stall_hit_s & stall_load_s);
        end else begin
            stall_s = 1'b0;
        end
    end

    assign issue_s = sb.id_valid & ~sb.flush & ~stall_s;

    // Per-source forward select for the EX instruction
    always_comb begin
        ex_fwd_sel_s = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (fwd_hit_s[s]) begin
                ex_fwd_sel_s[s*FWD_W +: FWD_W] = fwd_idx_s[s];
            end else begin
                ex_fwd_sel_s[s*FWD_W +: FWD_W] = FWD_W'(FWD_RF);
            end
        end
    end

    // Shift entries down the pipe; EX receives the ID instruction or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                flags_r[k] <= '0;
            end
            rd_r    <= '0;
            src0_r  <= '0;
            used0_r <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                flags_r[k] <= flags_r[k-1];
                rd_r[k]    <= rd_r[k-1];
            end
            if (issue_s) begin
                flags_r[STG_EX] <= '{valid: 1'b1,
                                     wr:    sb.id_we & (sb.id_rd != '0),
                                     load:  sb.id_load};
                rd_r[STG_EX]    <= sb.id_rd;
                src0_r          <= sb.id_src;
                used0_r         <= sb.id_src_used;
            end else begin
                flags_r[STG_EX] <= '0;
                rd_r[STG_EX]    <= '0;
                src0_r          <= '0;
                used0_r         <= '0;
            end
        end
    end

    assign sb.stall      = stall_s;
    assign sb.ex_fwd_sel = ex_fwd_sel_s;
    assign sb.ex_valid   = flags_r[STG_EX].valid;

`ifdef HAZARD_PERF_EN
    // Count stall cycles and cycles where any EX source is forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_fwd_cnt   <= 32'd0;
        end else begin
            if (stall_s) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
            if (|ex_fwd_sel_s) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end else begin
                perf_fwd_cnt <= perf_fwd_cnt;
            end
        end
    end
`endif

    hazard_scoreboard_chk #(
        .DEPTH      (DEPTH),
        .NUM_SRC    (NUM_SRC),
        .LOAD_STAGE (LOAD_STAGE),
        .FWD_W      (FWD_W)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .fwd_sel  (ex_fwd_sel_s),
        .fwd_load (fwd_load_s)
    );

endmodule
